// File: rtl/pipe_hazard_ctrl_if.sv
// Control/status bundle between the pipeline datapath and the hazard controller.
// The master drives the observed pipeline inputs; the slave is the controller.
interface pipe_hazard_ctrl_if;
  logic        enable;
  logic        step;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_pc_src;
  logic        pipe_en;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_m_flush;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output enable, step, id_instr, ex_mem_read, ex_rt, mem_pc_src,
    input  pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_m_flush,
    input  halted, state, cycle_count, stall_count, flush_count
  );

  modport slave (
    input  enable, step, id_instr, ex_mem_read, ex_rt, mem_pc_src,
    output pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_m_flush,
    output halted, state, cycle_count, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing controller: advance gating, load-use stalls, branch flushes,
// run/single-step, halt draining and performance counters.
module pipe_hazard_ctrl #(
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                step_q;
  logic [31:0]         cyc_q, cyc_d;
  logic [15:0]         stall_q, stall_d;
  logic [15:0]         flush_q, flush_d;

  logic step_edge, adv, halt_id, lu_haz;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_m_flush;
  logic unused_instr_bits;

  assign unused_instr_bits = ^bus.id_instr[15:0];

  assign step_edge = bus.step & ~step_q;
  assign adv       = (bus.enable | step_edge) & (state_q != StHalted) & ~rst;
  assign halt_id   = bus.id_instr[31:26] == HALT_OPCODE;
  assign lu_haz    = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                     ((bus.ex_rt == bus.id_instr[25:21]) | (bus.ex_rt == bus.id_instr[20:16])) &
                     ~halt_id;

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_flush  = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    cyc_d       = cyc_q;
    stall_d     = stall_q;
    flush_d     = flush_q;

    if (adv) begin
      cyc_d = cyc_q + 32'd1;
      if (bus.mem_pc_src) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_m_flush  = 1'b1;
        if (flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
        // A taken branch means any halt seen behind it was wrong-path.
        if (state_q == StDrain) begin
          state_d = StRun;
          drain_d = '0;
        end
      end else begin
        case (state_q)
          StRun: begin
            if (halt_id) begin
              if_id_write = 1'b1;
              if_id_flush = 1'b1;
              drain_d     = DrainW'(DRAIN_CYCLES);
              state_d     = StDrain;
            end else if (lu_haz) begin
              id_ex_flush = 1'b1;
              if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
            end else begin
              pc_write    = 1'b1;
              if_id_write = 1'b1;
            end
          end
          StDrain: begin
            // IF/ID holds a bubble here, so load-use cannot apply.
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            drain_d     = drain_q - 1'b1;
            if (drain_q == DrainW'(1)) state_d = StHalted;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= '0;
      step_q  <= 1'b0;
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      step_q  <= bus.step;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pipe_en     = adv;
  assign bus.pc_write    = pc_write;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_m_flush  = ex_m_flush;
  assign bus.halted      = (state_q == StHalted) & ~rst;
  assign bus.state       = state_q;
  assign bus.cycle_count = cyc_q;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tcyc = 0;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // {pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_m_flush, halted}
  localparam logic [6:0] ONone    = 7'b0000000;
  localparam logic [6:0] ORun     = 7'b1110000;
  localparam logic [6:0] OStall   = 7'b1000100;
  localparam logic [6:0] OBranch  = 7'b1111110;
  localparam logic [6:0] ODrain   = 7'b1011000;
  localparam logic [6:0] OHalted  = 7'b0000001;
  localparam logic [31:0] Halt    = 32'hFC000000;

  typedef struct {
    string       name;
    int          cyc;
    bit          is_cnt;
    logic [6:0]  outs;
    logic [1:0]  st;
    logic [31:0] cc;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [6:0] got_outs;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'd0};
  endfunction

  task automatic drv(input bit r, input bit en, input bit st, input logic [31:0] ins,
                     input bit mr, input logic [4:0] rt, input bit br);
    @(posedge clk);
    #1;
    rst             = r;
    bus.enable      = en;
    bus.step        = st;
    bus.id_instr    = ins;
    bus.ex_mem_read = mr;
    bus.ex_rt       = rt;
    bus.mem_pc_src  = br;
  endtask

  task automatic eo(input string name, input logic [6:0] outs, input logic [1:0] st);
    exp_t e;
    e.name = name; e.cyc = tcyc; e.is_cnt = 1'b0; e.outs = outs; e.st = st;
    e.cc = '0; e.sc = '0; e.fc = '0;
    q.push_back(e);
  endtask

  task automatic ec(input string name, input logic [31:0] cc, input logic [15:0] sc,
                    input logic [15:0] fc);
    exp_t e;
    e.name = name; e.cyc = tcyc; e.is_cnt = 1'b1; e.outs = '0; e.st = '0;
    e.cc = cc; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= tcyc) begin
      mon_e = q.pop_front();
      checks++;
      got_outs = {bus.pipe_en, bus.pc_write, bus.if_id_write, bus.if_id_flush,
                  bus.id_ex_flush, bus.ex_m_flush, bus.halted};
      if (mon_e.cyc != tcyc) begin
        errors++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", mon_e.name, tcyc,
                 mon_e.cyc);
      end else if (!mon_e.is_cnt) begin
        if (got_outs !== mon_e.outs || bus.state !== mon_e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b state=%0d, want outs=%b state=%0d", mon_e.name,
                   got_outs, bus.state, mon_e.outs, mon_e.st);
        end
      end else begin
        if (bus.cycle_count !== mon_e.cc || bus.stall_count !== mon_e.sc ||
            bus.flush_count !== mon_e.fc) begin
          errors++;
          $display("FAIL %s: got cyc=%0d stall=%0d flush=%0d, want cyc=%0d stall=%0d flush=%0d",
                   mon_e.name, bus.cycle_count, bus.stall_count, bus.flush_count,
                   mon_e.cc, mon_e.sc, mon_e.fc);
        end
      end
    end
  end

  initial begin
    bus.enable = 1'b0; bus.step = 1'b0; bus.id_instr = '0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.mem_pc_src = 1'b0;

    // Reset: outputs forced low even with enable, halt and branch present
    drv(1, 1, 0, Halt, 0, 0, 1); eo("rst_outs0", ONone, 2'd0);
    drv(1, 1, 0, Halt, 0, 0, 1); eo("rst_outs1", ONone, 2'd0); ec("rst_cnt", 0, 0, 0);

    // Run and load-use
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("run", ORun, 2'd0); ec("cnt0", 0, 0, 0);
    drv(0, 1, 0, mk(5, 3), 1, 5, 0); eo("lu_rs", OStall, 2'd0);
    drv(0, 1, 0, mk(7, 5), 1, 5, 0); eo("lu_rt", OStall, 2'd0); ec("cnt_lu1", 2, 1, 0);
    drv(0, 1, 0, mk(0, 0), 1, 0, 0); eo("lu_r0", ORun, 2'd0); ec("cnt_lu2", 3, 2, 0);

    // Branch with simultaneous load-use
    drv(0, 1, 0, mk(5, 0), 1, 5, 1); eo("br_lu", OBranch, 2'd0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("after_br", ORun, 2'd0); ec("cnt_br", 5, 2, 1);

    // Halt drain
    drv(0, 1, 0, Halt, 0, 0, 0);     eo("halt_det", ODrain, 2'd0);
    drv(0, 1, 0, mk(5, 5), 1, 5, 0); eo("drain1", ODrain, 2'd1);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("drain2", ODrain, 2'd1);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("drain3", ODrain, 2'd1);
    drv(0, 1, 0, mk(1, 2), 0, 0, 1); eo("halted", OHalted, 2'd2); ec("cnt_halt", 10, 2, 1);
    drv(0, 0, 1, mk(1, 2), 0, 0, 0); eo("halted_step", OHalted, 2'd2);
    ec("cnt_halt2", 10, 2, 1);
    drv(1, 1, 0, mk(1, 2), 0, 0, 0); eo("rst_in_halt", ONone, 2'd2);

    // Branch cancels drain
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("run2", ORun, 2'd0); ec("cnt_rst", 0, 0, 0);
    drv(0, 1, 0, Halt, 0, 0, 0);     eo("halt_det2", ODrain, 2'd0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("drain_b1", ODrain, 2'd1);
    drv(0, 1, 0, mk(1, 2), 0, 0, 1); eo("drain_br", OBranch, 2'd1);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("cancelled", ORun, 2'd0); ec("cnt_cancel", 4, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("no_halt", ORun, 2'd0);
    end

    // Single step
    drv(0, 0, 0, mk(1, 2), 0, 0, 0); eo("idle", ONone, 2'd0); ec("cnt_idle", 8, 0, 1);
    drv(0, 0, 1, mk(1, 2), 0, 0, 0); eo("step_edge", ORun, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, mk(1, 2), 0, 0, 0); eo("step_held", ONone, 2'd0);
    end
    ec("cnt_step", 9, 0, 1);
    drv(0, 1, 1, mk(1, 2), 0, 0, 0); eo("en_step_hi", ORun, 2'd0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("en_step_lo", ORun, 2'd0);
    drv(0, 1, 1, mk(1, 2), 0, 0, 0); eo("en_step_edge", ORun, 2'd0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("en_run", ORun, 2'd0); ec("cnt_en_step", 12, 0, 1);
    drv(0, 0, 0, mk(1, 2), 0, 0, 0); eo("idle2", ONone, 2'd0); ec("cnt_idle2", 13, 0, 1);
    drv(0, 0, 1, mk(5, 0), 1, 5, 0); eo("step_lu", OStall, 2'd0);
    drv(0, 0, 0, mk(5, 0), 1, 5, 0); eo("idle3", ONone, 2'd0); ec("cnt_step_lu", 14, 1, 1);

    // Reset mid-drain
    drv(0, 1, 0, Halt, 0, 0, 0);     eo("halt_det3", ODrain, 2'd0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("drain_r1", ODrain, 2'd1);
    drv(1, 1, 0, mk(1, 2), 0, 0, 0); eo("rst_drain", ONone, 2'd1);
    drv(0, 0, 0, mk(1, 2), 0, 0, 0); eo("post_rst", ONone, 2'd0); ec("cnt_rst2", 0, 0, 0);
    drv(0, 1, 0, mk(1, 2), 0, 0, 0); eo("run3", ORun, 2'd0);

    // Stall counter saturation
    for (int i = 0; i < 65540; i++) drv(0, 1, 0, mk(5, 0), 1, 5, 0);
    drv(0, 1, 0, mk(5, 0), 1, 5, 0); eo("sat_stall", OStall, 2'd0);
    ec("cnt_sat", 65541, 16'hFFFF, 0);
    drv(0, 0, 0, mk(5, 0), 1, 5, 0); eo("sat_idle", ONone, 2'd0);
    ec("cnt_sat2", 65542, 16'hFFFF, 0);

    drv(0, 0, 0, mk(1, 2), 0, 0, 0);
    drv(0, 0, 0, mk(1, 2), 0, 0, 0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expectations, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
